// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl_if
// Brief    : SRAM-like instruction bus (req/addr_ok/data_ok) between fetch and memory.
// Revision : 1.0
// ============================================================================
interface inst_fetch_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Brief    : Fetch-PC owner; one outstanding instruction request, redirects, ID handoff.
// Revision : 1.0
// ============================================================================
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'hbfc00000,
    parameter logic [31:0] EX_VECTOR = 32'hbfc00380
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          ds_allowin,
    input  wire logic          br_taken,
    input  wire logic [31:0]   br_target,
    input  wire logic          wb_ex,
    input  wire logic          eret_flush,
    input  wire logic [31:0]   epc,
    output logic               fs_to_ds_valid,
    output logic [64:0]        fs_to_ds_bus,
    inst_fetch_ctrl_if.master  inst_sram
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        cancel_q, cancel_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        ex_buf_q, ex_buf_d;

    logic        w_flush;
    logic [31:0] w_flush_target;
    logic        w_misaligned;
    logic        w_hold_exit;
    logic [31:0] w_next_pc;

    assign w_flush        = wb_ex | eret_flush;
    assign w_flush_target = wb_ex ? EX_VECTOR : epc;
    assign w_misaligned   = (pc_q[1:0] != 2'b00);
    assign w_hold_exit    = (state_q == S_HOLD) && ds_allowin && !w_flush;
    assign w_next_pc      = br_taken      ? br_target  :
                            redir_valid_q ? redir_pc_q :
                                            pc_q + 32'd4;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            cancel_q      <= 1'b0;
            inst_buf_q    <= 32'd0;
            ex_buf_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            cancel_q      <= cancel_d;
            inst_buf_q    <= inst_buf_d;
            ex_buf_q      <= ex_buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (w_misaligned)
                    state_d = w_flush ? S_REQ : S_HOLD;
                else if (inst_sram.addr_ok)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                // A flush coinciding with the return drops the word right away.
                if (inst_sram.data_ok)
                    state_d = (cancel_q || w_flush) ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
                if (w_flush || ds_allowin)
                    state_d = S_REQ;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        cancel_d      = cancel_q;
        inst_buf_d    = inst_buf_q;
        ex_buf_d      = ex_buf_q;

        if (w_flush) begin
            pc_d          = w_flush_target;
            redir_valid_d = 1'b0;
        end else if (w_hold_exit) begin
            pc_d = w_next_pc;
            if (!br_taken && redir_valid_q)
                redir_valid_d = 1'b0;
        end else if (br_taken) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = br_target;
        end

        case (state_q)
            S_REQ: begin
                if (w_misaligned) begin
                    if (!w_flush) begin
                        ex_buf_d   = 1'b1;
                        inst_buf_d = 32'd0;
                    end
                end else if (inst_sram.addr_ok) begin
                    cancel_d = w_flush;
                end
            end
            S_WAIT: begin
                if (inst_sram.data_ok) begin
                    cancel_d = 1'b0;
                    if (!cancel_q && !w_flush) begin
                        inst_buf_d = inst_sram.rdata;
                        ex_buf_d   = 1'b0;
                    end
                end else if (w_flush) begin
                    cancel_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        inst_sram.req  = (state_q == S_REQ) && !w_misaligned;
        fs_to_ds_valid = (state_q == S_HOLD);
    end

    assign inst_sram.addr  = pc_q;
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = 2'd2;
    assign inst_sram.wstrb = 4'd0;
    assign inst_sram.wdata = 32'd0;
    assign fs_to_ds_bus    = {ex_buf_q, inst_buf_q, pc_q};

endmodule
`default_nettype wire
